roberts_sharpen_mc: RTL
=======================

Name: roberts_sharpen_mc

Overview:
- Parametrised successor of the single-channel Roberts sharpen stage.
- Processes CHANNELS independent DATA_WIDTH-bit pixel planes in one stream. Example: CHANNELS=3 for RGB888.
- Runtime mode select: bypass, sharpen with programmable gain shift, gradient magnitude, or thresholded binary edge.
- Sits between the video-stream source and sink in the image pipeline. Keeps the pre_img_* / post_img_* stream convention, with fixed latency and delayed syncs.

Parameters:
- DATA_WIDTH, 8, bits per channel.
- CHANNELS, 1, number of parallel planes; pixel bus is CHANNELS*DATA_WIDTH bits, channel 0 in the LSBs.
- MAX_WIDTH, 1024, line-buffer depth in pixels (maximum active pixels per line).
- VSYNC_POL, 1, active level of pre_img_vsync.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- pre_img_vsync  in  1  frame sync.
- pre_img_hsync  in  1  line sync.
- pre_img_valid  in  1  pixel valid; contiguous within a line.
- pre_img_data  in  CHANNELS*DATA_WIDTH  input pixel.
- mode  in  2  0 bypass, 1 sharpen, 2 gradient, 3 binary edge.
- gain_shift  in  3  sharpen gradient right-shift s.
- thresh  in  DATA_WIDTH  binary-edge threshold.
- post_img_vsync  out  1  pre_img_vsync delayed 3 cycles.
- post_img_hsync  out  1  pre_img_hsync delayed 3 cycles.
- post_img_valid  out  1  pre_img_valid delayed 3 cycles.
- post_img_data  out  CHANNELS*DATA_WIDTH  processed pixel.
- line_overflow  out  1  sticky: a line exceeded MAX_WIDTH.

Behaviour:
- Reset: all post_img_* outputs = 0, line_overflow = 0, counters = 0. Latched mode = 0 (bypass), latched shift = 0, latched thresh = 0. Line-buffer contents are don't-care.
- Reset mid-frame: outputs go to 0 on the next clk edge and the pipeline is flushed. Processing is bypass until the next vsync start edge.
- Frame start = pre_img_vsync transitions to VSYNC_POL. On that cycle:
  - mode, gain_shift and thresh are latched;
  - row counter is cleared;
  - line_overflow is cleared.
  - Control inputs are otherwise ignored mid-frame.
- Column counter:
  - increments per valid pixel;
  - clears on the cycle after a valid falling edge;
  - saturates at MAX_WIDTH.
- Row counter increments on each valid falling edge.
- Line buffer: one line deep, written at the column address with the current pixel every valid cycle, read at the same address (read-before-write).
- Window per channel:
  - p11 = current pixel; p10 = previous pixel, current line;
  - p01 = same column, previous line; p00 = previous column, previous line.
  - Borders: row 0 of a frame uses p01 = p11 and p00 = p10. Column 0 uses p10 = p11 and p00 = p01. Pixel (0,0) therefore gives G = 0.
- Arithmetic, per channel, unsigned: G = |p11-p00| + |p10-p01|, DATA_WIDTH+1 bits, no loss.
  - mode 0: out = p11.
  - mode 1: out = sat(p11 + (G >> s)), sum DATA_WIDTH+2 bits, saturated to 2^DATA_WIDTH-1.
  - mode 2: out = sat(G).
  - mode 3: out = all-ones if G >= thresh, else 0.
- Pipeline:
  - stage 1: buffer read plus pixel/column registers;
  - stage 2: absolute differences;
  - stage 3: sum, shift, saturate, output register.
  - Latency is exactly 3 cycles for data and all syncs, with no throughput loss.
  - post_img_data = 0 when post_img_valid = 0.
- Overflow: pixels at column >= MAX_WIDTH are passed through as p11 (bypass), are not written to the buffer, and set line_overflow. The flag holds until the next frame start or reset.
- Simultaneous frame start and valid: the pixel is treated as row 0, using the newly latched controls.

Test Plan:
- Flat 800x600 frame, all channels = 100, mode 1, s = 1 -> every output = 100. Valid and syncs equal the inputs delayed exactly 3 cycles.
- Vertical step, columns 0-399 = 50 and 400-799 = 200, mode 2 -> column 400 of every row = 255 (G = 300 saturated), all other pixels = 0.
- Same step, mode 1, s = 2 -> column 400 = 255 (200+75 saturated), column 399 = 50, column 401 = 200.
- Mode 3, thresh = 128, CHANNELS = 3, steps 20->60 on channel 0 and 0->255 on channel 2 -> channel 0 all 0 (G = 80). Channel 2 = 255 at the step column and 0 elsewhere. Channel 1 (flat) all 0.
- mode changed 1->2 at row 300 -> rest of frame still sharpen; next frame gradient. A line of MAX_WIDTH+4 pixels -> last 4 pixels bypassed and line_overflow = 1 until the next vsync start.
- rst pulsed mid-line -> all outputs 0 on the next edge. After release, data is passed unchanged (bypass) until the first vsync start, then the programmed mode applies.

Source files
------------

// File: rtl/roberts_sharpen_mc.sv
// Roberts-cross sharpen / edge stage for CHANNELS parallel pixel planes.
// Three stages: window fetch, absolute differences, combine + saturate; syncs follow the data.
module roberts_sharpen_mc #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CHANNELS   = 1,
  parameter int unsigned MAX_WIDTH  = 1024,
  parameter bit          VSYNC_POL  = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pre_img_vsync,
  input  logic                           pre_img_hsync,
  input  logic                           pre_img_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0] pre_img_data,
  input  logic [1:0]                     mode,
  input  logic [2:0]                     gain_shift,
  input  logic [DATA_WIDTH-1:0]          thresh,
  output logic                           post_img_vsync,
  output logic                           post_img_hsync,
  output logic                           post_img_valid,
  output logic [CHANNELS*DATA_WIDTH-1:0] post_img_data,
  output logic                           line_overflow
);
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned PW = CHANNELS * DATA_WIDTH;
  localparam int unsigned CW = $clog2(MAX_WIDTH + 1);
  localparam int unsigned AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int unsigned RW = 16;

  typedef struct packed {
    logic          vs;
    logic          hs;
    logic          valid;
    logic          row0;
    logic          col0;
    logic          ovf;
    logic [1:0]    mode;
    logic [2:0]    shift;
    logic [DW-1:0] thresh;
    logic [PW-1:0] p11;
    logic [PW-1:0] p10;
    logic [PW-1:0] p00;
  } s1_t;

  typedef struct packed {
    logic          vs;
    logic          hs;
    logic          valid;
    logic          ovf;
    logic [1:0]    mode;
    logic [2:0]    shift;
    logic [DW-1:0] thresh;
    logic [PW-1:0] p11;
    logic [PW-1:0] d1;
    logic [PW-1:0] d2;
  } s2_t;

  typedef struct packed {
    logic          vs;
    logic          hs;
    logic          valid;
    logic [PW-1:0] data;
  } out_t;

  s1_t           s1_d, s1_q;
  s2_t           s2_d, s2_q;
  out_t          out_d, out_q;
  logic [CW-1:0] col_d, col_q;
  logic [RW-1:0] row_d, row_q;
  logic [1:0]    mode_d, mode_q;
  logic [2:0]    shift_d, shift_q;
  logic [DW-1:0] thresh_d, thresh_q;
  logic          ovf_d, ovf_q;
  logic          vs_start, at_limit;
  logic [AW-1:0] addr;
  logic [PW-1:0] line_mem [MAX_WIDTH];
  logic [PW-1:0] rd_q;
  logic [DW-1:0] a11, a10, a01, a00, pix;
  logic [DW:0]   g;
  logic [DW+1:0] sum;
  logic [DW-1:0] res;

  assign vs_start = (pre_img_vsync == VSYNC_POL) && (s1_q.vs != VSYNC_POL);
  assign at_limit = (col_q >= CW'(MAX_WIDTH));
  assign addr     = col_q[AW-1:0];

  // Read-before-write: rd_q returns the previous line's pixel at this column.
  always_ff @(posedge clk) begin
    if (pre_img_valid && !at_limit) line_mem[addr] <= pre_img_data;
    rd_q <= line_mem[addr];
  end

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    mode_d   = mode_q;
    shift_d  = shift_q;
    thresh_d = thresh_q;
    ovf_d    = ovf_q;
    if (pre_img_valid) col_d = at_limit ? col_q : col_q + CW'(1);
    else if (s1_q.valid) col_d = '0;
    if (vs_start) begin
      row_d    = '0;
      mode_d   = mode;
      shift_d  = gain_shift;
      thresh_d = thresh;
      ovf_d    = 1'b0;
    end else if (s1_q.valid && !pre_img_valid && (row_q != '1)) begin
      row_d = row_q + RW'(1);
    end
    if (pre_img_valid && at_limit) ovf_d = 1'b1;

    // Controls come from *_d so a pixel coincident with frame start sees the new settings.
    s1_d.vs     = pre_img_vsync;
    s1_d.hs     = pre_img_hsync;
    s1_d.valid  = pre_img_valid;
    s1_d.row0   = vs_start || (row_q == '0);
    s1_d.col0   = (col_q == '0);
    s1_d.ovf    = pre_img_valid && at_limit;
    s1_d.mode   = mode_d;
    s1_d.shift  = shift_d;
    s1_d.thresh = thresh_d;
    s1_d.p11    = pre_img_data;
    s1_d.p10    = s1_q.p11;
    s1_d.p00    = rd_q;
  end

  always_comb begin
    s2_d        = '0;
    s2_d.vs     = s1_q.vs;
    s2_d.hs     = s1_q.hs;
    s2_d.valid  = s1_q.valid;
    s2_d.ovf    = s1_q.ovf;
    s2_d.mode   = s1_q.mode;
    s2_d.shift  = s1_q.shift;
    s2_d.thresh = s1_q.thresh;
    s2_d.p11    = s1_q.p11;
    a11 = '0;
    a10 = '0;
    a01 = '0;
    a00 = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      a11 = s1_q.p11[c*DW +: DW];
      a10 = s1_q.col0 ? a11 : s1_q.p10[c*DW +: DW];
      a01 = s1_q.row0 ? a11 : rd_q[c*DW +: DW];
      a00 = s1_q.row0 ? a10 : (s1_q.col0 ? a01 : s1_q.p00[c*DW +: DW]);
      s2_d.d1[c*DW +: DW] = (a11 >= a00) ? a11 - a00 : a00 - a11;
      s2_d.d2[c*DW +: DW] = (a10 >= a01) ? a10 - a01 : a01 - a10;
    end
  end

  always_comb begin
    out_d       = '0;
    out_d.vs    = s2_q.vs;
    out_d.hs    = s2_q.hs;
    out_d.valid = s2_q.valid;
    g   = '0;
    sum = '0;
    res = '0;
    pix = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      pix = s2_q.p11[c*DW +: DW];
      g   = {1'b0, s2_q.d1[c*DW +: DW]} + {1'b0, s2_q.d2[c*DW +: DW]};
      sum = {2'b00, pix} + {1'b0, g >> s2_q.shift};
      unique case (s2_q.mode)
        2'd0: res = pix;
        2'd1: res = (sum[DW+1:DW] != 2'b00) ? '1 : sum[DW-1:0];
        2'd2: res = g[DW] ? '1 : g[DW-1:0];
        2'd3: res = (g >= {1'b0, s2_q.thresh}) ? '1 : '0;
      endcase
      if (s2_q.ovf) res = pix;
      if (s2_q.valid) out_d.data[c*DW +: DW] = res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q    <= '0;
      row_q    <= '0;
      mode_q   <= '0;
      shift_q  <= '0;
      thresh_q <= '0;
      ovf_q    <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
      out_q    <= '0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      mode_q   <= mode_d;
      shift_q  <= shift_d;
      thresh_q <= thresh_d;
      ovf_q    <= ovf_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      out_q    <= out_d;
    end
  end

  assign post_img_vsync = out_q.vs;
  assign post_img_hsync = out_q.hs;
  assign post_img_valid = out_q.valid;
  assign post_img_data  = out_q.data;
  assign line_overflow  = ovf_q;

endmodule
